xbar_out_alloc: RTL and testbench
=================================

# xbar_out_alloc

Per-output-port allocator for the PSNoC crossbar. Sits directly downstream of the priority-arbiter stage. It turns the raw per-input request vector into a fair, packet-locked grant:
- round-robin is implemented by masking requests above the last winner and feeding two priority arbiters;
- the grant is held from head flit to tail flit;
- the granted input's flits are multiplexed into a registered valid/ready output.

## Interface
Parameters:
- NUM_IN, 4, number of crossbar inputs competing for this output (≥2).
- DATA_WIDTH, 64, flit payload width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  NUM_IN  per-input flit valid.
- in_last  in  NUM_IN  per-input tail-flit marker.
- in_data  in  NUM_IN*DATA_WIDTH  packed flits; input i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  NUM_IN  per-input accept.
- out_valid  out  1  output flit valid.
- out_last  out  1  output tail marker.
- out_data  out  DATA_WIDTH  output flit.
- out_ready  in  1  downstream accept.
- owner  out  NUM_IN  one-hot current lock holder; zero when IDLE.

## Operation
- States: IDLE, LOCKED. Reset → IDLE.
- IDLE:
  - Compute reqs = in_valid.
  - Compute mask = bits strictly above ptr (ptr = index of last packet winner).
  - hi = arb(reqs & mask); lo = arb(reqs). Each arb returns the lowest-index set bit.
  - win = hi if (reqs & mask) ≠ 0, else lo.
  - If win ≠ 0: owner ← win, go to LOCKED. No flit is accepted in IDLE.
- LOCKED:
  - in_ready[i] = owner[i] & (~out_valid | out_ready). Non-owners have in_ready = 0.
  - An input transfer occurs when in_valid & in_ready for the owner. The output register then loads data and last from that input, and out_valid ← 1.
  - If the output register drains (out_valid & out_ready) with no new load, out_valid ← 0.
  - If the transferred flit has last = 1: ptr ← index(owner), owner ← 0, go to IDLE.
  - An owner deasserting in_valid mid-packet keeps the lock; there is no timeout.
- Requests from non-owners have no effect while LOCKED. The new mask is applied at the next IDLE.
- Output flits are never dropped or duplicated. out_data, out_last and out_valid hold stable while out_valid & ~out_ready.

## Timing
- Reset values:
  - out_valid = 0, out_last = 0, out_data = 0;
  - owner = 0, in_ready = 0;
  - ptr = NUM_IN-1, so input 0 has top priority first.
- Reset asserted mid-packet clears all state immediately. A partially forwarded packet is discarded, and upstream must also reset.
- Latency:
  - head flit presented in cycle 0 with the allocator IDLE;
  - cycle 0: arbitration; cycle 1: in_ready high;
  - out_valid visible in cycle 2.
- Throughput: 1 flit/cycle inside a packet while out_ready = 1.
- Re-arbitration costs exactly one IDLE bubble cycle between packets.
- Tail accepted together with out_ready high: the output still holds the tail in the next cycle (IDLE). It drains independently of the new arbitration. A new owner's first load waits until the register is free.
- Simultaneous drain and load in the same cycle: the register takes the new flit and out_valid stays 1.
- ptr wrap: ptr = NUM_IN-1 gives mask = 0, so lo is selected (lowest index wins).

## Structure
- Shared package psnoc_pkg: a flit-field helper for the DATA_WIDTH slice and the state encoding (IDLE=0, LOCKED=1).
- Sub-module: reuse the team's combinational priority arbiter p_arbiter (WORD_WIDTH = NUM_IN, grants = reqs & -reqs), instantiated twice (masked and unmasked).
- Mask generation and one-hot→index conversion stay local.

## Test plan
- Reset: after rst_n release, in_valid = 4'b1111, all single-flit packets, out_ready = 1. Grants occur in order 0,1,2,3,0. Each out_data equals that input's tag. One bubble between packets.
- Fairness: inputs 1 and 3 continuously requesting with ptr = 1. Owner sequence is 3,1,3,1. Input 1 is never granted twice in a row.
- Lock: input 2 sends a 4-flit packet, and input 0 asserts valid at flit 2. Owner stays 4'b0100 until the tail. out_last is high only on flit 4. Input 0 is granted next.
- Backpressure: out_ready toggles 1,0,0,1 during a 3-flit packet. out_data is stable while stalled. in_ready is 0 whenever out_valid & ~out_ready. Exactly 3 flits are delivered in order.
- Mid-packet owner gap: the owner drops in_valid for 3 cycles between flits 1 and 2. Owner is unchanged and no other input gets in_ready.
- Async reset: rst_n asserted mid-packet without a clock edge. out_valid, owner and in_ready go 0 immediately. After release, input 0 has priority.

Source files
------------

// File: rtl/psnoc_pkg.sv
// Shared PSNoC types and helpers for the crossbar allocator.
// Provides the allocator state encoding and the flit-slice offset helper.
package psnoc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bit offset of input idx inside a packed flit bus
    function automatic int flit_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/p_arbiter.sv
// Combinational fixed-priority arbiter: lowest-index request wins.
// Ports: reqs (request vector), grants (one-hot or zero grant).
module p_arbiter #(
    parameter int WORD_WIDTH = 4
) (
    input  logic [WORD_WIDTH-1:0] reqs,
    output logic [WORD_WIDTH-1:0] grants
);

    // Two's complement isolates the lowest set bit
    assign grants = reqs & (-reqs);

endmodule

// File: rtl/xbar_out_alloc.sv
// Per-output round-robin, packet-locked allocator with registered output.
// Ports: clk, rst_n, in_valid/in_last/in_data/in_ready (per input),
//        out_valid/out_last/out_data/out_ready (output), owner (lock holder).
module xbar_out_alloc
    import psnoc_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_last,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [NUM_IN-1:0]            owner
);

    localparam int IW = $clog2(NUM_IN);

    state_t                state_q, state_nx;
    logic [NUM_IN-1:0]     owner_q, owner_nx;
    logic [IW-1:0]         ptr_q, ptr_nx;
    logic [IW-1:0]         owner_idx;
    logic [NUM_IN-1:0]     mask;
    logic [NUM_IN-1:0]     masked;
    logic [NUM_IN-1:0]     hi, lo, win;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  xfer;
    logic                  xfer_last;

    // Requests strictly above the last winner get first chance
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            mask[i] = (i > int'(ptr_q));
        end
    end

    assign masked = in_valid & mask;

    p_arbiter #(.WORD_WIDTH(NUM_IN)) u_arb_hi (
        .reqs   (masked),
        .grants (hi)
    );

    p_arbiter #(.WORD_WIDTH(NUM_IN)) u_arb_lo (
        .reqs   (in_valid),
        .grants (lo)
    );

    assign win = (|masked) ? hi : lo;

    // Owner mux and one-hot to index
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        owner_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (owner_q[i]) begin
                sel_data  = in_data[flit_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
                sel_last  = in_last[i];
                owner_idx = IW'(i);
            end
        end
    end

    assign in_ready = (state_q == LOCKED)
                    ? (owner_q & {NUM_IN{~out_valid | out_ready}})
                    : '0;

    assign xfer      = |(owner_q & in_valid & in_ready);
    assign xfer_last = xfer & sel_last;

    always_comb begin
        state_nx = state_q;
        owner_nx = owner_q;
        ptr_nx   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|win) begin
                    owner_nx = win;
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer_last) begin
                    ptr_nx   = owner_idx;
                    owner_nx = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                owner_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_IN - 1);
        end else begin
            state_q <= state_nx;
            owner_q <= owner_nx;
            ptr_q   <= ptr_nx;
        end
    end

    // Output register: load wins over drain so back-to-back flits flow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_data  <= sel_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_xbar_out_alloc.sv
// Directed self-checking bench for xbar_out_alloc.
// Scenario tasks drive vectors and compare against hand-computed values.
module tb_xbar_out_alloc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [255:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_last;
    logic [63:0]  out_data;
    logic         out_ready;
    logic [3:0]   owner;
    logic [63:0]  src [4];

    int errors = 0;
    int checks = 0;

    assign in_data = {src[3], src[2], src[1], src[0]};

    always #5 clk = ~clk;

    xbar_out_alloc #(.NUM_IN(4), .DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .owner     (owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_owner();
        for (int n = 0; n < 6 && owner == 4'b0; n++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '0;
        in_last = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) src[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_last: got %b want 0", out_last);
        end
        checks++;
        if (out_data !== 64'h0) begin
            errors++;
            $display("FAIL rst_out_data: got %h want 0", out_data);
        end
        checks++;
        if (owner !== 4'b0) begin
            errors++;
            $display("FAIL rst_owner: got %b want 0000", owner);
        end
        checks++;
        if (in_ready !== 4'b0) begin
            errors++;
            $display("FAIL rst_in_ready: got %b want 0000", in_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_o;
        for (int i = 0; i < 4; i++) src[i] = 64'hA0 + 64'(i);
        in_valid = 4'hF;
        in_last = 4'hF;
        out_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_o = 4'b0001 << (k % 4);
            wait_owner();
            checks++;
            if (owner !== exp_o) begin
                errors++;
                $display("FAIL rr_owner[%0d]: got %b want %b", k, owner, exp_o);
            end
            checks++;
            if (in_ready !== exp_o) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, exp_o);
            end
            tick();
            checks++;
            if (owner !== 4'b0) begin
                errors++;
                $display("FAIL rr_bubble[%0d]: got %b want 0000", k, owner);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'hA0 + 64'(k % 4)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got v=%b %h want v=1 %h",
                         k, out_valid, out_data, 64'hA0 + 64'(k % 4));
            end
        end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_o;
        src[1] = 64'hB1;
        src[3] = 64'hB3;
        in_last = 4'hF;
        in_valid = 4'b0010;
        wait_owner();
        tick();
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_o = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            wait_owner();
            checks++;
            if (owner !== exp_o) begin
                errors++;
                $display("FAIL fair_owner[%0d]: got %b want %b", k, owner, exp_o);
            end
            tick();
            checks++;
            if (out_data !== ((k % 2 == 0) ? 64'hB3 : 64'hB1)) begin
                errors++;
                $display("FAIL fair_data[%0d]: got %h", k, out_data);
            end
        end
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_lock();
        in_last = '0;
        src[0] = 64'hB0;
        src[2] = 64'hC1;
        in_valid = 4'b0100;
        wait_owner();
        for (int f = 1; f <= 4; f++) begin
            src[2] = 64'hC0 + 64'(f);
            in_last[2] = (f == 4);
            if (f >= 2) begin
                in_valid[0] = 1'b1;
                in_last[0] = 1'b1;
            end
            #1;
            checks++;
            if (owner !== 4'b0100) begin
                errors++;
                $display("FAIL lock_owner[%0d]: got %b want 0100", f, owner);
            end
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL lock_ready[%0d]: got %b want 0100", f, in_ready);
            end
            tick();
            checks++;
            if (out_data !== 64'hC0 + 64'(f) || out_last !== 1'(f == 4)) begin
                errors++;
                $display("FAIL lock_flit[%0d]: got %h last=%b want %h last=%b",
                         f, out_data, out_last, 64'hC0 + 64'(f), f == 4);
            end
        end
        in_valid[2] = 1'b0;
        #1;
        checks++;
        if (owner !== 4'b0) begin
            errors++;
            $display("FAIL lock_release: got %b want 0000", owner);
        end
        tick();
        checks++;
        if (owner !== 4'b0001) begin
            errors++;
            $display("FAIL lock_next: got %b want 0001", owner);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_data !== 64'hB0) begin
            errors++;
            $display("FAIL lock_next_data: got %h want b0", out_data);
        end
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        int f = 0;
        int got = 0;
        logic [3:0] exp_r;
        logic [63:0] exp_d;
        logic fire;
        src[3] = 64'hD0;
        in_last = '0;
        in_valid = 4'b1000;
        out_ready = 1'b1;
        wait_owner();
        for (int c = 0; c < 6; c++) begin
            out_ready = !(c == 1 || c == 2);
            in_valid[3] = (f < 3);
            src[3] = 64'hD0 + 64'(f);
            in_last[3] = (f == 2);
            exp_r = (c == 1 || c == 2 || c == 5) ? 4'b0 : 4'b1000;
            exp_d = (c <= 3) ? 64'hD0 : ((c == 4) ? 64'hD1 : 64'hD2);
            #1;
            checks++;
            if (in_ready !== exp_r) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, in_ready, exp_r);
            end
            checks++;
            if (out_valid !== 1'(c != 0)) begin
                errors++;
                $display("FAIL bp_valid[%0d]: got %b want %b", c, out_valid, c != 0);
            end
            if (c != 0) begin
                checks++;
                if (out_data !== exp_d) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got %h want %h", c, out_data, exp_d);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 64'hD0 + 64'(got)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h want %h",
                             got, out_data, 64'hD0 + 64'(got));
                end
                got++;
            end
            fire = in_valid[3] && in_ready[3];
            tick();
            if (fire) f++;
        end
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d want 3", got);
        end
        in_valid = '0;
        out_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_gap();
        src[1] = 64'hE1;
        src[2] = 64'hF2;
        in_last = 4'b0100;
        in_valid = 4'b0110;
        wait_owner();
        checks++;
        if (owner !== 4'b0010) begin
            errors++;
            $display("FAIL gap_owner: got %b want 0010", owner);
        end
        tick();
        for (int g = 1; g <= 3; g++) begin
            in_valid[1] = 1'b0;
            #1;
            checks++;
            if (owner !== 4'b0010 || in_ready !== 4'b0010) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got owner=%b ready=%b want 0010",
                         g, owner, in_ready);
            end
            tick();
        end
        in_valid[1] = 1'b1;
        src[1] = 64'hE2;
        in_last[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        #1;
        checks++;
        if (owner !== 4'b0 || out_data !== 64'hE2 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL gap_tail: got owner=%b %h last=%b want 0000 e2 1",
                     owner, out_data, out_last);
        end
        tick();
        checks++;
        if (owner !== 4'b0100) begin
            errors++;
            $display("FAIL gap_next: got %b want 0100", owner);
        end
        tick();
        in_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        src[3] = 64'h31;
        in_last = '0;
        in_valid = 4'b1000;
        wait_owner();
        checks++;
        if (owner !== 4'b1000) begin
            errors++;
            $display("FAIL ar_owner: got %b want 1000", owner);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || owner !== 4'b0 || in_ready !== 4'b0) begin
            errors++;
            $display("FAIL ar_clear: got v=%b owner=%b ready=%b want 0",
                     out_valid, owner, in_ready);
        end
        src[0] = 64'h0F;
        in_last = 4'b1001;
        in_valid = 4'b1001;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (owner !== 4'b0001) begin
            errors++;
            $display("FAIL ar_prio: got %b want 0001", owner);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_data !== 64'h0F) begin
            errors++;
            $display("FAIL ar_data: got %h want 0f", out_data);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fairness();
        test_lock();
        test_backpressure();
        test_gap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
